// File: rtl/seq_blink_if.sv
// seq_blink_if: value handshake between the sequence generator and the
// blink encoder.
//   num_in    : 16-bit value to display       (generator -> encoder)
//   num_valid : num_in is valid               (generator -> encoder)
//   num_ready : encoder can accept a value    (encoder -> generator)
// Modports: master = generator side, slave = encoder side.
interface seq_blink_if;
  logic [15:0] num_in;
  logic        num_valid;
  logic        num_ready;

  modport master (output num_in, output num_valid, input num_ready);
  modport slave  (input num_in, input num_valid, output num_ready);
endinterface

// File: rtl/seq_blink_encoder.sv
// seq_blink_encoder: takes a 16-bit value over a valid/ready handshake,
// converts it to 5 BCD digits (shift-add-3, one bit per cycle) and blinks
// each digit on a single LED, most significant digit first. A nonzero digit
// is shown as that many PULSE_CYCLES pulses; a zero digit is shown as one
// long pulse of ZERO_MULT*PULSE_CYCLES cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : global enable, all state holds while low
//   bus        : seq_blink_if.slave (num_in, num_valid, num_ready)
//   led        : blink output
//   busy       : high from the accept cycle until back in IDLE
//   digit_out  : BCD digit currently shown
//   digit_idx  : index of that digit (4 = ten-thousands .. 0 = units)
//   word_done  : one-cycle pulse on the final word-gap cycle
// Optional feature: define SEQ_ENC_ZERO_SUPPRESS_EN to skip leading zero
// digits; otherwise all five digits are always shown.
module seq_blink_encoder #(
  parameter int PULSE_CYCLES     = 4,
  parameter int ZERO_MULT        = 3,
  parameter int DIGIT_GAP_CYCLES = 6,
  parameter int WORD_GAP_CYCLES  = 8,
  parameter int TIMER_W          = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  seq_blink_if.slave   bus,
  output logic         led,
  output logic         busy,
  output logic [3:0]   digit_out,
  output logic [2:0]   digit_idx,
  output logic         word_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_SELECT, S_ON, S_ZERO, S_OFF, S_DGAP, S_WGAP
  } state_t;

  localparam logic [TIMER_W-1:0] PULSE_T = TIMER_W'(PULSE_CYCLES);
  localparam logic [TIMER_W-1:0] ZERO_T  = TIMER_W'(ZERO_MULT * PULSE_CYCLES);
  localparam logic [TIMER_W-1:0] DGAP_T  = TIMER_W'(DIGIT_GAP_CYCLES);
  localparam logic [TIMER_W-1:0] WGAP_T  = TIMER_W'(WORD_GAP_CYCLES);
  localparam logic [TIMER_W-1:0] ONE_T   = TIMER_W'(1);

  state_t             state_r, state_nx;
  logic [TIMER_W-1:0] timer_r, timer_nx;
  logic [15:0]        bin_r, bin_nx;
  logic [19:0]        bcd_r, bcd_nx;
  logic [3:0]         bit_cnt_r, bit_cnt_nx;
  logic [3:0]         pulse_cnt_r, pulse_cnt_nx;
  logic [3:0]         digit_out_r, digit_out_nx;
  logic [2:0]         digit_idx_r, digit_idx_nx;
  logic               led_r, busy_r, ready_r, word_done_r;
  logic               load_s;
  logic [2:0]         load_idx_s;
  logic [3:0]         dig_s;
  logic [35:0]        shift_s;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [19:0] add3_bcd(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 0; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      else                     r[i*4 +: 4] = r[i*4 +: 4];
    end
    return r;
  endfunction

`ifdef SEQ_ENC_ZERO_SUPPRESS_EN
  // Highest nonzero digit; a value of 0 still starts at the units digit.
  function automatic logic [2:0] start_idx(input logic [19:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (v[i*4 +: 4] != 4'd0) r = 3'(i);
      else                     r = r;
    end
    return r;
  endfunction
`else
  function automatic logic [2:0] start_idx(input logic [19:0] v);
    return (v == 20'd0) ? 3'd4 : 3'd4;
  endfunction
`endif

  // Next-state and datapath decode for the convert / blink sequencer.
  always_comb begin
    state_nx     = state_r;
    timer_nx     = timer_r;
    bin_nx       = bin_r;
    bcd_nx       = bcd_r;
    bit_cnt_nx   = bit_cnt_r;
    pulse_cnt_nx = pulse_cnt_r;
    digit_out_nx = digit_out_r;
    digit_idx_nx = digit_idx_r;
    load_s       = 1'b0;
    load_idx_s   = 3'd0;
    shift_s      = {add3_bcd(bcd_r), bin_r} << 1;
    dig_s        = 4'd0;

    case (state_r)
      S_IDLE: begin
        if (bus.num_valid) begin
          bin_nx     = bus.num_in;
          bcd_nx     = 20'd0;
          bit_cnt_nx = 4'd0;
          state_nx   = S_CONVERT;
        end else begin
          state_nx   = S_IDLE;
        end
      end
      S_CONVERT: begin
        bcd_nx     = shift_s[35:16];
        bin_nx     = shift_s[15:0];
        bit_cnt_nx = bit_cnt_r + 4'd1;
        if (bit_cnt_r == 4'd15) state_nx = S_SELECT;
        else                    state_nx = S_CONVERT;
      end
      S_SELECT: begin
        load_s     = 1'b1;
        load_idx_s = start_idx(bcd_r);
      end
      S_ON: begin
        if (timer_r == ONE_T) begin
          pulse_cnt_nx = pulse_cnt_r - 4'd1;
          if (pulse_cnt_r != 4'd1) begin
            state_nx = S_OFF;
            timer_nx = PULSE_T;
          end else begin
            state_nx = S_DGAP;
            timer_nx = DGAP_T;
          end
        end else begin
          timer_nx = timer_r - ONE_T;
        end
      end
      S_ZERO: begin
        if (timer_r == ONE_T) begin
          state_nx = S_DGAP;
          timer_nx = DGAP_T;
        end else begin
          timer_nx = timer_r - ONE_T;
        end
      end
      S_OFF: begin
        if (timer_r == ONE_T) begin
          state_nx = S_ON;
          timer_nx = PULSE_T;
        end else begin
          timer_nx = timer_r - ONE_T;
        end
      end
      S_DGAP: begin
        if (timer_r == ONE_T) begin
          if (digit_idx_r == 3'd0) begin
            state_nx = S_WGAP;
            timer_nx = WGAP_T;
          end else begin
            load_s     = 1'b1;
            load_idx_s = digit_idx_r - 3'd1;
          end
        end else begin
          timer_nx = timer_r - ONE_T;
        end
      end
      S_WGAP: begin
        if (timer_r == ONE_T) begin
          state_nx = S_IDLE;
          timer_nx = timer_r - ONE_T;
        end else begin
          timer_nx = timer_r - ONE_T;
        end
      end
      default: begin
        state_nx = S_IDLE;
        timer_nx = {TIMER_W{1'b0}};
      end
    endcase

    // Shared digit load used by SELECT and by DGAP moving to the next digit.
    if (load_s) begin
      dig_s        = bcd_r[{load_idx_s, 2'b00} +: 4];
      digit_out_nx = dig_s;
      digit_idx_nx = load_idx_s;
      pulse_cnt_nx = dig_s;
      if (dig_s != 4'd0) begin
        state_nx = S_ON;
        timer_nx = PULSE_T;
      end else begin
        state_nx = S_ZERO;
        timer_nx = ZERO_T;
      end
    end else begin
      dig_s = 4'd0;
    end
  end

  // State, datapath and registered outputs; everything freezes while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      timer_r     <= {TIMER_W{1'b0}};
      bin_r       <= 16'd0;
      bcd_r       <= 20'd0;
      bit_cnt_r   <= 4'd0;
      pulse_cnt_r <= 4'd0;
      digit_out_r <= 4'd0;
      digit_idx_r <= 3'd0;
      led_r       <= 1'b0;
      busy_r      <= 1'b0;
      ready_r     <= 1'b1;
      word_done_r <= 1'b0;
    end else if (ena) begin
      state_r     <= state_nx;
      timer_r     <= timer_nx;
      bin_r       <= bin_nx;
      bcd_r       <= bcd_nx;
      bit_cnt_r   <= bit_cnt_nx;
      pulse_cnt_r <= pulse_cnt_nx;
      digit_out_r <= digit_out_nx;
      digit_idx_r <= digit_idx_nx;
      // Outputs are decoded from the next state so they line up with it.
      led_r       <= (state_nx == S_ON) || (state_nx == S_ZERO);
      busy_r      <= (state_nx != S_IDLE);
      ready_r     <= (state_nx == S_IDLE);
      word_done_r <= (state_nx == S_WGAP) && (timer_nx == ONE_T);
    end
  end

  assign bus.num_ready = ready_r;
  assign led           = led_r;
  assign busy          = busy_r;
  assign digit_out     = digit_out_r;
  assign digit_idx     = digit_idx_r;
  assign word_done     = word_done_r;

endmodule

// File: tb/tb_seq_blink_encoder.sv
// Testbench for seq_blink_encoder. The reference model expands a value into
// the expected per-cycle LED / busy / word_done / digit trace straight from
// the decimal digits of the value and the timing parameters.
module tb_seq_blink_encoder;
  localparam int PC = 4;
  localparam int ZM = 3;
  localparam int DG = 6;
  localparam int WG = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       led, busy, word_done;
  logic [3:0] digit_out;
  logic [2:0] digit_idx;

  seq_blink_if bus_if ();

  seq_blink_encoder #(
    .PULSE_CYCLES(PC), .ZERO_MULT(ZM), .DIGIT_GAP_CYCLES(DG),
    .WORD_GAP_CYCLES(WG), .TIMER_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus_if.slave),
    .led(led), .busy(busy), .digit_out(digit_out), .digit_idx(digit_idx),
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       led;
    logic       busy;
    logic       wd;
    logic       chk;
    logic [3:0] dig;
    logic [2:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   model_high = 0;

  task automatic push(input logic l, input logic b, input logic w, input logic c,
                      input int d, input int i, input int n);
    exp_t e;
    e.led = l; e.busy = b; e.wd = w; e.chk = c;
    e.dig = 4'(d); e.idx = 3'(i);
    for (int k = 0; k < n; k++) exp_q.push_back(e);
    if (l) model_high += n;
  endtask

  // Expected trace starting with the first cycle after the accept edge.
  task automatic build(input int n);
    int d[5];
    int v, start;
    exp_q.delete();
    model_high = 0;
    v = n;
    for (int i = 0; i < 5; i++) begin d[i] = v % 10; v = v / 10; end
    start = 4;
`ifdef SEQ_ENC_ZERO_SUPPRESS_EN
    start = 0;
    for (int i = 0; i < 5; i++) if (d[i] != 0) start = i;
`endif
    push(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 17);
    for (int i = start; i >= 0; i--) begin
      if (d[i] == 0) push(1'b1, 1'b1, 1'b0, 1'b1, 0, i, ZM * PC);
      else begin
        for (int p = 1; p <= d[i]; p++) begin
          push(1'b1, 1'b1, 1'b0, 1'b1, d[i], i, PC);
          if (p < d[i]) push(1'b0, 1'b1, 1'b0, 1'b1, d[i], i, PC);
        end
      end
      push(1'b0, 1'b1, 1'b0, 1'b1, d[i], i, DG);
    end
    push(1'b0, 1'b1, 1'b0, 1'b1, d[0], 0, WG - 1);
    push(1'b0, 1'b1, 1'b1, 1'b1, d[0], 0, 1);
    push(1'b0, 1'b0, 1'b0, 1'b1, d[0], 0, 1);
  endtask

  // Offers n, then follows the whole word cycle by cycle against the model.
  // A cycle whose edge had ena low must repeat the previous observation.
  task automatic run_word(input int n, input bit rnd_ena, input bit toggle_valid,
                          output int high_cnt);
    exp_t e, prev;
    int   idx, guard;
    bit   took;
    build(n);
    high_cnt = 0;
    @(negedge clk);
    vectors++;
    if (bus_if.num_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_accept n=%0d got=%b want=1", n, bus_if.num_ready);
    end
    bus_if.num_in = 16'(n);
    bus_if.num_valid = 1'b1;
    ena = 1'b1;
    idx = 0; guard = 0; prev = '0;
    while (idx < exp_q.size() && guard < 5000) begin
      guard++;
      @(posedge clk);
      took = ena;
      @(negedge clk);
      if (took) begin e = exp_q[idx]; idx++; end
      else e = prev;
      if (took && led === 1'b1) high_cnt++;
      vectors++;
      if ({led, busy, word_done, bus_if.num_ready} !== {e.led, e.busy, e.wd, ~e.busy}) begin
        miscompares++;
        $display("FAIL ctrl n=%0d step=%0d got led/busy/wd/rdy=%b%b%b%b want=%b%b%b%b",
                 n, idx, led, busy, word_done, bus_if.num_ready, e.led, e.busy, e.wd, ~e.busy);
      end
      if (e.chk) begin
        vectors++;
        if ({digit_out, digit_idx} !== {e.dig, e.idx}) begin
          miscompares++;
          $display("FAIL digit n=%0d step=%0d got dig=%0d idx=%0d want dig=%0d idx=%0d",
                   n, idx, digit_out, digit_idx, e.dig, e.idx);
        end
      end
      prev = e;
      bus_if.num_in = 16'($urandom_range(0, 65535));
      bus_if.num_valid = (toggle_valid && idx < exp_q.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
      ena = rnd_ena ? ($urandom_range(0, 7) != 0) : 1'b1;
    end
    ena = 1'b1;
    bus_if.num_valid = 1'b0;
    if (guard >= 5000) begin
      miscompares++;
      $display("FAIL timeout n=%0d got_steps=%0d want=%0d", n, idx, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.num_valid = 1'b0;
    bus_if.num_in = 16'd0;
    ena = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({led, busy, word_done, bus_if.num_ready, digit_out, digit_idx} !== 11'b0001_0000_000) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got=%b want=00010000000", i,
                 {led, busy, word_done, bus_if.num_ready, digit_out, digit_idx});
      end
    end
  endtask

  task automatic test_pattern(input int n);
    int hc;
    run_word(n, 1'b0, 1'b0, hc);
    vectors++;
    if (hc !== model_high) begin
      miscompares++;
      $display("FAIL high_count n=%0d got=%0d want=%0d", n, hc, model_high);
    end
`ifndef SEQ_ENC_ZERO_SUPPRESS_EN
    if (n == 7) begin
      vectors++;
      if (hc !== 76) begin
        miscompares++;
        $display("FAIL high_count_7 got=%0d want=76", hc);
      end
    end
`endif
  endtask

  task automatic test_back_to_back();
    int hc;
    run_word(65535, 1'b0, 1'b0, hc);
    run_word(21, 1'b0, 1'b0, hc);
  endtask

  task automatic test_busy_toggle();
    int hc;
    run_word(3, 1'b0, 1'b1, hc);
    run_word(40906, 1'b0, 1'b1, hc);
  endtask

  task automatic test_random();
    int hc;
    for (int k = 0; k < 6; k++) run_word(int'($urandom_range(0, 65535)), 1'b1, 1'b1, hc);
  endtask

  task automatic test_ena_stretch();
    int guard, run, wd_cnt;
    @(negedge clk);
    bus_if.num_in = 16'd11111;
    bus_if.num_valid = 1'b1;
    @(negedge clk);
    bus_if.num_valid = 1'b0;
    guard = 0;
    while (led !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    run = 1;
    @(negedge clk);
    if (led === 1'b1) run++;
    ena = 1'b0;
    repeat (5) begin @(negedge clk); if (led === 1'b1) run++; end
    ena = 1'b1;
    guard = 0;
    @(negedge clk);
    while (led === 1'b1 && guard < 100) begin run++; @(negedge clk); guard++; end
    vectors++;
    if (run !== PC + 5) begin
      miscompares++;
      $display("FAIL ena_stretch got=%0d want=%0d", run, PC + 5);
    end
    wd_cnt = 0; guard = 0;
    while (busy === 1'b1 && guard < 2000) begin
      if (word_done === 1'b1) wd_cnt++;
      @(negedge clk); guard++;
    end
    vectors++;
    if (wd_cnt !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ena_word_done got wd=%0d busy=%b want wd=1 busy=0", wd_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_word();
    int guard, wd_cnt;
    @(negedge clk);
    bus_if.num_in = 16'd10;
    bus_if.num_valid = 1'b1;
    @(negedge clk);
    bus_if.num_valid = 1'b0;
    guard = 0;
    while (led !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    while (led === 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({led, busy, word_done, bus_if.num_ready, digit_out, digit_idx} !== 11'b0001_0000_000) begin
      miscompares++;
      $display("FAIL reset_mid_word got=%b want=00010000000",
               {led, busy, word_done, bus_if.num_ready, digit_out, digit_idx});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wd_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (word_done === 1'b1 || busy === 1'b1) wd_cnt++;
    end
    vectors++;
    if (wd_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_no_word_done got=%0d want=0", wd_cnt);
    end
  endtask

  initial begin
    bus_if.num_in = 16'd0;
    bus_if.num_valid = 1'b0;
    test_reset();
    test_pattern(3);
    test_pattern(0);
    test_pattern(21);
    test_pattern(65535);
    test_pattern(7);
    test_back_to_back();
    test_busy_toggle();
    test_ena_stretch();
    test_reset_mid_word();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
